// File: rtl/serial_pkg.sv
// Shared serial-link constants and the transmitter state encoding.
// The receiver on the same link imports the baud constants from here as well.
package serial_pkg;

    localparam int unsigned CLOCK      = 56842105;
    localparam int unsigned BAUD_RATE  = 115200;
    localparam int unsigned BIT_PERIOD = CLOCK / BAUD_RATE;

    // Width of the bit-period counter; bounds BIT_PERIOD to 65535.
    localparam int unsigned COUNTER_W  = 16;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_REQ,
        TX_LOAD,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

endpackage

// File: rtl/serial_out_if.sv
// FIFO-side and line-side signals of the UART transmitter.
// The master modport belongs to the system that feeds bytes and watches the line.
interface serial_out_if;

    logic       enable;
    logic       fifo_empty;
    logic [7:0] data;
    logic       fifo_read_req;
    logic       serial_tx;
    logic       busy;

    modport master (
        output enable,
        output fifo_empty,
        output data,
        input  fifo_read_req,
        input  serial_tx,
        input  busy
    );

    modport slave (
        input  enable,
        input  fifo_empty,
        input  data,
        output fifo_read_req,
        output serial_tx,
        output busy
    );

endinterface

// File: rtl/serial_bit_timer.sv
// Bit-period timer: counts 0..BIT_PERIOD-1 while not cleared and flags the last count.
// The count restarts from zero on the cycle after the terminal count.
module serial_bit_timer
    import serial_pkg::*;
#(
    parameter int unsigned BIT_PERIOD = serial_pkg::BIT_PERIOD
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    output logic terminal
);

    localparam logic [COUNTER_W-1:0] LAST = COUNTER_W'(BIT_PERIOD - 1);

    logic [COUNTER_W-1:0] count;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear || terminal) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign terminal = !clear && (count == LAST);

endmodule

// File: rtl/serial_out.sv
// UART 8N1 transmitter draining a show-behind FIFO (one-cycle read latency).
// Each frame: pop (REQ), capture (LOAD), start bit, eight data bits LSB first, stop bit.
module serial_out #(
    parameter int unsigned CLOCK      = serial_pkg::CLOCK,
    parameter int unsigned BAUD_RATE  = serial_pkg::BAUD_RATE,
    parameter int unsigned BIT_PERIOD = CLOCK / BAUD_RATE
) (
    input  logic         i_clock,
    input  logic         i_reset,
    serial_out_if.slave  bus
);

    import serial_pkg::*;

    tx_state_t  state;
    tx_state_t  state_next;
    logic [7:0] shift_reg;
    logic [2:0] bit_ptr;
    logic       tx;
    logic       timer_clear;
    logic       bit_done;

    serial_bit_timer #(
        .BIT_PERIOD (BIT_PERIOD)
    ) u_bit_timer (
        .clock    (i_clock),
        .reset    (i_reset),
        .clear    (timer_clear),
        .terminal (bit_done)
    );

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state <= TX_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        // NOTE: default first so every path assigns state_next and no latch is inferred.
        state_next = state;
        unique case (state)
            TX_IDLE:  if (bus.enable && !bus.fifo_empty) state_next = TX_REQ;
            TX_REQ:   state_next = TX_LOAD;
            TX_LOAD:  state_next = TX_START;
            TX_START: if (bit_done) state_next = TX_DATA;
            TX_DATA:  if (bit_done && bit_ptr == 3'd7) state_next = TX_STOP;
            TX_STOP:  if (bit_done) state_next = TX_IDLE;
            default:  state_next = TX_IDLE;
        endcase
    end

    always_comb begin
        bus.fifo_read_req = (state == TX_REQ);
        bus.busy          = (state != TX_IDLE);
        // The timer only runs while a bit is on the line; LOAD parks it at zero for the start bit.
        timer_clear       = (state == TX_IDLE) || (state == TX_REQ) || (state == TX_LOAD);
    end

    // Line register and shifter; tx is a flop so the line only moves on a clock edge.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            tx        <= 1'b1;
            // NOTE: the byte buffer is reset as well; it costs little and keeps the flops out of X.
            shift_reg <= '0;
            bit_ptr   <= '0;
        end else begin
            unique case (state)
                TX_IDLE: begin
                    tx <= 1'b1;
                end
                TX_LOAD: begin
                    shift_reg <= bus.data;
                    tx        <= 1'b0;
                end
                TX_START: begin
                    if (bit_done) begin
                        tx      <= shift_reg[0];
                        bit_ptr <= '0;
                    end
                end
                TX_DATA: begin
                    if (bit_done) begin
                        if (bit_ptr == 3'd7) begin
                            tx <= 1'b1;
                        end else begin
                            bit_ptr <= bit_ptr + 3'd1;
                            tx      <= shift_reg[bit_ptr + 3'd1];
                        end
                    end
                end
                TX_STOP: begin
                    tx <= 1'b1;
                end
                default: begin
                    tx <= 1'b1;
                end
            endcase
        end
    end

    assign bus.serial_tx = tx;

    // The line must rest high whenever no frame is in flight.
    a_idle_high: assert property (@(posedge i_clock) disable iff (i_reset)
        (state == TX_IDLE) |-> tx);

    // A pop is only ever issued for a byte the FIFO reported as present.
    a_no_underflow: assert property (@(posedge i_clock) disable iff (i_reset)
        (state == TX_REQ) |-> ($past(state) == TX_IDLE && !$past(bus.fifo_empty)));

endmodule
